// File: rtl/tama_host_if.sv
// Request/response handshake between the save/debug path and the TAMA5 host.
// The master drives requests; the slave (tama_host) reports status and read data.
interface tama_host_if;
    logic       req;
    logic       req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] rdata;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  busy, done, err, rdata
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output busy, done, err, rdata
    );
endinterface

// File: rtl/tama_host.sv
// TAMA5 initiator: turns one byte RAM read/write request into the nibble-register
// bus sequence at $A000/$A001, unlocking the mapper first when needed.
module tama_host #(
    parameter int unsigned WAIT_CE = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_cpu,
    tama_host_if.slave  host,
    output logic [14:0] cart_addr,
    output logic        cart_a15,
    output logic        nCS,
    output logic        cart_wr,
    output logic        cart_rd,
    output logic [7:0]  cart_di,
    input  logic [7:0]  cart_do
);

    typedef enum logic [2:0] {StIdle, StUnlock, StSeq, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        we_q, we_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        unlocked_q, unlocked_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  lo_q, lo_d;

    logic        acc;
    logic        is_idx;
    logic        is_rd;
    logic [3:0]  nib;
    logic        unused_do_hi;

    assign unused_do_hi = ^cart_do[7:4];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            step_q     <= 4'd0;
            wcnt_q     <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 5'd0;
            wdata_q    <= 8'd0;
            unlocked_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 8'd0;
            lo_q       <= 4'd0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wcnt_q     <= wcnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            unlocked_q <= unlocked_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        wcnt_d     = wcnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        unlocked_d = unlocked_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        lo_d       = lo_q;
        acc        = 1'b0;
        is_idx     = 1'b0;
        is_rd      = 1'b0;
        nib        = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (host.req) begin
                    we_d    = host.req_we;
                    addr_d  = host.req_addr;
                    wdata_d = host.req_wdata;
                    err_d   = 1'b0;
                    step_d  = 4'd0;
                    state_d = unlocked_q ? StSeq : StUnlock;
                end
            end
            StUnlock: begin
                acc    = 1'b1;
                is_idx = ~step_q[0];
                is_rd  = step_q[0];
                nib    = 4'hA;
                if (ce_cpu) begin
                    if (!step_q[0]) begin
                        step_d = 4'd1;
                    end else if (cart_do[3:0] == 4'h1) begin
                        unlocked_d = 1'b1;
                        step_d     = 4'd0;
                        state_d    = StSeq;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StSeq: begin
                acc    = 1'b1;
                is_idx = ~step_q[0];
                // Even steps select a register on $A001, odd steps move its nibble on $A000.
                if (we_q) begin
                    unique case (step_q[2:1])
                        2'd0:    nib = is_idx ? 4'h4 : wdata_q[3:0];
                        2'd1:    nib = is_idx ? 4'h5 : wdata_q[7:4];
                        2'd2:    nib = is_idx ? 4'h6 : {3'b000, addr_q[4]};
                        default: nib = is_idx ? 4'h7 : addr_q[3:0];
                    endcase
                end else begin
                    is_rd = step_q[2] & step_q[0];
                    unique case (step_q[2:1])
                        2'd0:    nib = is_idx ? 4'h6 : {3'b001, addr_q[4]};
                        2'd1:    nib = is_idx ? 4'h7 : addr_q[3:0];
                        2'd2:    nib = 4'hC;
                        default: nib = 4'hD;
                    endcase
                end
                if (ce_cpu) begin
                    if (!we_q && step_q == 4'd5) lo_d = cart_do[3:0];
                    if (!we_q && step_q == 4'd7) rdata_d = {cart_do[3:0], lo_q};
                    if ((we_q && step_q == 4'd7) || (!we_q && step_q == 4'd3)) begin
                        wcnt_d  = 4'd0;
                        step_d  = step_q + 4'd1;
                        state_d = StWait;
                    end else if (step_q == 4'd7) begin
                        state_d = StDone;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end
            end
            StWait: begin
                if (ce_cpu) begin
                    if (wcnt_q == 4'(WAIT_CE - 1)) begin
                        state_d = we_q ? StDone : StSeq;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign host.busy  = (state_q != StIdle) && (state_q != StDone);
    assign host.done  = (state_q == StDone);
    assign host.err   = err_q;
    assign host.rdata = rdata_q;

    assign nCS       = ~acc;
    assign cart_a15  = acc;
    assign cart_addr = acc ? (is_idx ? 15'h2001 : 15'h2000) : 15'h0000;
    assign cart_wr   = acc & ~is_rd;
    assign cart_rd   = acc & is_rd;
    assign cart_di   = (acc && !is_rd) ? {4'h0, nib} : 8'h00;

endmodule

// File: tb/tb_tama_host.sv
// Scoreboard bench for tama_host: a transaction-level model predicts bus accesses and
// results; a negedge monitor checks them while a small TAMA5 mapper model answers reads.
module tb_tama_host;
    localparam int unsigned WAIT_CE = 4;

    typedef struct {
        bit          rd;
        logic [14:0] addr;
        logic [7:0]  di;
        int          gap;
    } acc_t;

    typedef struct {
        bit         err;
        logic [7:0] rdata;
        int         gap;
    } done_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_cpu  = 1'b0;
    logic [14:0] cart_addr;
    logic        cart_a15, nCS, cart_wr, cart_rd;
    logic [7:0]  cart_di, cart_do;

    tama_host_if hif ();

    tama_host #(.WAIT_CE(WAIT_CE)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ce_cpu    (ce_cpu),
        .host      (hif),
        .cart_addr (cart_addr),
        .cart_a15  (cart_a15),
        .nCS       (nCS),
        .cart_wr   (cart_wr),
        .cart_rd   (cart_rd),
        .cart_di   (cart_di),
        .cart_do   (cart_do)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;

    acc_t  exp_acc[$];
    done_t exp_done[$];
    int    issued = 0;
    int    n_done = 0;
    int    gap_cnt = 0;

    // Reference model state
    logic [7:0] m_ram [32];
    bit         m_unlocked = 1'b0;
    logic [7:0] m_rdata = 8'h00;

    // Cartridge mapper model
    logic [7:0] cram [32];
    logic [3:0] regs [16];
    logic [3:0] last_idx = 4'h0;
    logic [7:0] rd_latch = 8'h00;
    logic [3:0] unlock_val = 4'h1;
    logic [3:0] junk = 4'h0;

    int ce_mode = 0;
    bit ce_en = 1'b1;
    int ce_cnt = 0;

    always_comb begin
        cart_do = {junk, 4'h0};
        case (last_idx)
            4'hA:    cart_do[3:0] = unlock_val;
            4'hC:    cart_do[3:0] = rd_latch[3:0];
            4'hD:    cart_do[3:0] = rd_latch[7:4];
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // CPU clock enable generator
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            ce_cnt++;
            if (!ce_en) ce_cpu = 1'b0;
            else case (ce_mode)
                0:       ce_cpu = (ce_cnt % 4 == 0);
                1:       ce_cpu = 1'($urandom_range(0, 1));
                default: ce_cpu = 1'b1;
            endcase
        end
    end

    // Monitor: pops expectations when the DUT completes an access or signals done
    initial begin
        acc_t  e;
        done_t d;
        logic [4:0] ca;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                gap_cnt = 0;
            end else begin
                if (ce_cpu && hif.busy && nCS) gap_cnt++;
                if (ce_cpu && (cart_wr || cart_rd)) begin
                    if (exp_acc.size() == 0) begin
                        fail("unexpected_access", 1, 0);
                    end else begin
                        e = exp_acc.pop_front();
                        check("acc_rd", cart_rd, e.rd);
                        check("acc_addr", cart_addr, e.addr);
                        if (!e.rd) check("acc_di", cart_di, e.di);
                        check("acc_gap", gap_cnt, e.gap);
                        check("acc_a15_ncs", {cart_a15, nCS}, 2'b10);
                    end
                    gap_cnt = 0;
                    if (cart_wr) begin
                        if (cart_addr == 15'h2001) begin
                            last_idx = cart_di[3:0];
                        end else begin
                            regs[last_idx] = cart_di[3:0];
                            if (last_idx == 4'h7) begin
                                ca = {regs[6][0], cart_di[3:0]};
                                if (regs[6][1]) rd_latch = cram[ca];
                                else cram[ca] = {regs[5], regs[4]};
                            end
                        end
                    end
                    junk = 4'($urandom);
                end
                if (hif.done) begin
                    if (exp_done.size() == 0) begin
                        fail("unexpected_done", 1, 0);
                    end else begin
                        d = exp_done.pop_front();
                        check("done_err", hif.err, d.err);
                        check("done_rdata", hif.rdata, d.rdata);
                        check("done_gap", gap_cnt, d.gap);
                        check("done_busy", hif.busy, 0);
                        check("done_missing_acc", exp_acc.size(), 0);
                    end
                    n_done++;
                    gap_cnt = 0;
                end
            end
        end
    end

    task automatic push_acc(input bit rd, input logic [14:0] a, input logic [7:0] di,
                            input int gap);
        acc_t e;
        e.rd = rd; e.addr = a; e.di = di; e.gap = gap;
        exp_acc.push_back(e);
    endtask

    // Register select on $A001 followed by a nibble write (or read) on $A000
    task automatic push_reg(input logic [3:0] idx, input logic [3:0] val, input bit rd,
                            input int gap);
        push_acc(1'b0, 15'h2001, {4'h0, idx}, gap);
        push_acc(rd, 15'h2000, {4'h0, val}, 0);
    endtask

    task automatic push_done(input bit err, input logic [7:0] rdata, input int gap);
        done_t d;
        d.err = err; d.rdata = rdata; d.gap = gap;
        exp_done.push_back(d);
    endtask

    task automatic issue(input bit we, input logic [4:0] a, input logic [7:0] d);
        @(posedge clk_sys);
        #1;
        hif.req = 1'b1; hif.req_we = we; hif.req_addr = a; hif.req_wdata = d;
        @(posedge clk_sys);
        #1;
        hif.req = 1'b0;
        issued++;
    endtask

    task automatic do_txn(input bit we, input logic [4:0] a, input logic [7:0] d);
        if (!m_unlocked) begin
            push_reg(4'hA, 4'h0, 1'b1, 0);
            if (unlock_val != 4'h1) begin
                push_done(1'b1, m_rdata, 0);
                issue(we, a, d);
                return;
            end
            m_unlocked = 1'b1;
        end
        if (we) begin
            push_reg(4'h4, d[3:0], 1'b0, 0);
            push_reg(4'h5, d[7:4], 1'b0, 0);
            push_reg(4'h6, {3'b000, a[4]}, 1'b0, 0);
            push_reg(4'h7, a[3:0], 1'b0, 0);
            m_ram[a] = d;
            push_done(1'b0, m_rdata, WAIT_CE);
        end else begin
            push_reg(4'h6, {3'b001, a[4]}, 1'b0, 0);
            push_reg(4'h7, a[3:0], 1'b0, 0);
            push_reg(4'hC, 4'h0, 1'b1, WAIT_CE);
            push_reg(4'hD, 4'h0, 1'b1, 0);
            m_rdata = m_ram[a];
            push_done(1'b0, m_rdata, 0);
        end
        issue(we, a, d);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000; i++) begin
            if (n_done >= issued) return;
            @(negedge clk_sys);
        end
        fail("done_timeout", n_done, issued);
        n_done = issued;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {hif.busy, hif.done, hif.err, hif.rdata, nCS, cart_wr, cart_rd, cart_a15,
                     cart_addr, cart_di},
              {3'b000, 8'h00, 1'b1, 3'b000, 15'h0000, 8'h00});
    endtask

    initial begin
        int         bad;
        bit         found;
        acc_t       front;
        logic [7:0] v;
        hif.req = 1'b0; hif.req_we = 1'b0; hif.req_addr = 5'd0; hif.req_wdata = 8'd0;
        for (int i = 0; i < 16; i++) regs[i] = 4'h0;
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            cram[i] = v;
            m_ram[i] = v;
        end
        cram[5] = 8'hE7;
        m_ram[5] = 8'hE7;

        #12;
        check_reset_outputs("reset_outputs");
        @(negedge clk_sys);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk_sys);
            if (!nCS || hif.busy || hif.done) bad++;
        end
        check("idle_no_access", bad, 0);

        // Unlock plus write, then a second write without unlock, then a read
        do_txn(1'b1, 5'h13, 8'h5A);
        wait_done();
        do_txn(1'b1, 5'h02, 8'hC3);
        wait_done();
        do_txn(1'b0, 5'h05, 8'h00);
        wait_done();

        // Frozen ce_cpu must hold the current step; a req while busy is ignored
        do_txn(1'b1, 5'h1F, 8'h81);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (hif.busy && !nCS && !ce_cpu) begin
                found = 1'b1;
                break;
            end
        end
        if (!found || exp_acc.size() == 0) begin
            fail("freeze_setup", 0, 1);
        end else begin
            ce_en = 1'b0;
            front = exp_acc[0];
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk_sys);
                if (cart_rd !== front.rd || cart_addr !== front.addr || nCS !== 1'b0) bad++;
                if (!front.rd && cart_di !== front.di) bad++;
                if (i == 20) begin
                    @(posedge clk_sys);
                    #1;
                    hif.req = 1'b1; hif.req_we = 1'b0; hif.req_addr = 5'h07;
                    check("busy_during_ignored_req", hif.busy, 1);
                    @(posedge clk_sys);
                    #1;
                    hif.req = 1'b0;
                end
            end
            check("freeze_hold", bad, 0);
            ce_en = 1'b1;
        end
        wait_done();
        do_txn(1'b0, 5'h1F, 8'h00);
        wait_done();

        // Reset during the WAIT of a read
        do_txn(1'b0, 5'h05, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_sys);
            if (hif.busy && nCS) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail("wait_not_reached", 0, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midtxn_reset_outputs");
        exp_acc.delete();
        exp_done.delete();
        m_unlocked = 1'b0;
        m_rdata = 8'h00;
        repeat (3) @(negedge clk_sys);
        check("reset_no_done", hif.done, 0);
        #1;
        reset_n = 1'b1;
        issued = n_done;

        // Failed unlock aborts with err, and the next request retries
        unlock_val = 4'h0;
        do_txn(1'b1, 5'h03, 8'h44);
        wait_done();
        repeat (5) @(negedge clk_sys);
        check("err_held", hif.err, 1);
        check("abort_bus_idle", {nCS, cart_a15}, 2'b10);
        do_txn(1'b0, 5'h03, 8'h00);
        wait_done();
        unlock_val = 4'h1;
        do_txn(1'b0, 5'h05, 8'h00);
        wait_done();

        // Randomized traffic across ce_cpu patterns
        for (int n = 0; n < 40; n++) begin
            ce_mode = $urandom_range(0, 2);
            do_txn(1'($urandom), 5'($urandom), 8'($urandom));
            wait_done();
        end
        repeat (5) @(negedge clk_sys);
        check("leftover_acc", exp_acc.size(), 0);
        check("leftover_done", exp_done.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
